// File: rtl/serial_rx_if.sv
// rtl/serial_rx_if.sv - CPU read-port bundle for the serial receiver
interface serial_rx_if;
  logic        sel;
  logic        re;
  logic [31:0] addr;
  logic [31:0] dout;

  modport master (output sel, output re, output addr, input dout);
  modport slave  (input sel, input re, input addr, output dout);
endinterface

// File: rtl/serial_rx.sv
// rtl/serial_rx.sv - memory-mapped 8N1 UART receiver with receive FIFO
module serial_rx #(
  parameter int CLK_FREQ   = 10000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic          clock_i,
  input  logic          reset_i,
  input  logic          rx_i,
  serial_rx_if.slave    bus,
  output logic          rx_avail_o,
  output logic          overrun_o,
  output logic          frm_err_o
);

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int AW  = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t          state_q, state_d;
  logic            rx_meta_q, rx_sync_q;
  logic [CW-1:0]   tick_cnt_q;
  logic            tick;
  logic [SW-1:0]   s_cnt_q, s_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            push, frm_set;
  logic            start_mid, bit_end;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW:0]     wr_ptr_q, rd_ptr_q;
  logic            empty, full, pop, ovr_set, stat_clr;
  logic            rd_req, rd_req_q, rd_edge;
  logic            overrun_q, frm_err_q;
  logic [7:0]      head_byte;
  logic            unused_addr;

  assign unused_addr = ^{bus.addr[31:3], bus.addr[1:0]};

  // Two-flop synchroniser; idles high so reset does not look like a start bit.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Free-running oversample tick divider.
  always_ff @(posedge clock_i) begin
    if (reset_i || tick) tick_cnt_q <= '0;
    else                 tick_cnt_q <= tick_cnt_q + 1'b1;
  end
  assign tick = (tick_cnt_q == CW'(DIV - 1));

  assign start_mid = tick && (s_cnt_q == SW'(OVERSAMPLE / 2 - 1));
  assign bit_end   = tick && (s_cnt_q == SW'(OVERSAMPLE - 1));

  // FSM state register.
  always_ff @(posedge clock_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (tick && !rx_sync_q) state_d = S_START;
      S_START: if (start_mid) state_d = rx_sync_q ? S_IDLE : S_DATA;
      S_DATA:  if (bit_end && bit_cnt_q == 3'd7) state_d = S_STOP;
      S_STOP:  if (bit_end) state_d = rx_sync_q ? S_IDLE : S_BREAK;
      S_BREAK: if (tick && rx_sync_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: sample counters, shift register and push/framing strobes.
  always_comb begin
    s_cnt_d   = s_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frm_set   = 1'b0;
    case (state_q)
      S_IDLE: begin
        s_cnt_d   = '0;
        bit_cnt_d = '0;
      end
      S_START: if (tick) s_cnt_d = start_mid ? '0 : s_cnt_q + 1'b1;
      S_DATA: if (tick) begin
        s_cnt_d = s_cnt_q + 1'b1;
        if (bit_end) begin
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      S_STOP: if (tick) begin
        s_cnt_d = s_cnt_q + 1'b1;
        if (bit_end) begin
          push    = rx_sync_q;
          frm_set = !rx_sync_q;
        end
      end
      default: ;
    endcase
  end

  // Receive datapath registers; a reset discards any partial byte.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      s_cnt_q   <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      s_cnt_q   <= s_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

  assign rd_req   = bus.sel & bus.re;
  assign rd_edge  = rd_req & ~rd_req_q;
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop      = rd_edge & ~bus.addr[2] & ~empty;
  assign stat_clr = rd_edge & bus.addr[2];
  assign ovr_set  = push & full & ~pop;

  // Registered copy of the read strobe so a held read acts only once.
  always_ff @(posedge clock_i) begin
    if (reset_i) rd_req_q <= 1'b0;
    else         rd_req_q <= rd_req;
  end

  // FIFO pointers; a full FIFO still accepts a push when a pop frees the slot.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push && (!full || pop)) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)                    rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // FIFO storage; contents are never visible while empty, so no reset needed.
  always_ff @(posedge clock_i) begin
    if (push && (!full || pop)) mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
  end

  // Sticky error flags; a same-cycle set beats the STATUS-read clear.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      overrun_q <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      if (ovr_set)       overrun_q <= 1'b1;
      else if (stat_clr) overrun_q <= 1'b0;
      if (frm_set)       frm_err_q <= 1'b1;
      else if (stat_clr) frm_err_q <= 1'b0;
    end
  end

  assign head_byte  = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
  assign rx_avail_o = ~empty;
  assign overrun_o  = overrun_q;
  assign frm_err_o  = frm_err_q;

  // Zero-latency read mux: DATA or STATUS by addr[2].
  always_comb begin
    if (bus.addr[2]) bus.dout = {28'b0, frm_err_q, overrun_q, full, ~empty};
    else             bus.dout = {23'b0, ~empty, head_byte};
  end

endmodule

// File: tb/tb_serial_rx.sv
// tb/tb_serial_rx.sv - directed self-checking bench for serial_rx
module tb_serial_rx;
  localparam int CLK_FREQ  = 2000000;
  localparam int BAUD      = 62500;
  localparam int OS        = 16;
  localparam int BIT_CLKS  = CLK_FREQ / BAUD;
  localparam int GLITCH    = BIT_CLKS / 4;

  logic clk;
  logic reset;
  logic rx;
  logic rx_avail, overrun, frm_err;
  logic [31:0] rd;
  int n_cmp;
  int n_err;

  serial_rx_if bus_if ();

  serial_rx #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS), .FIFO_DEPTH(16)
  ) dut (
    .clock_i(clk), .reset_i(reset), .rx_i(rx), .bus(bus_if),
    .rx_avail_o(rx_avail), .overrun_o(overrun), .frm_err_o(frm_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  task automatic peek(input logic a2, output logic [31:0] d);
    @(negedge clk);
    bus_if.addr = {29'b0, a2, 2'b0};
    #1 d = bus_if.dout;
  endtask

  task automatic cpu_read(input logic a2, output logic [31:0] d);
    @(negedge clk);
    bus_if.sel  = 1'b1;
    bus_if.re   = 1'b1;
    bus_if.addr = {29'b0, a2, 2'b0};
    #1 d = bus_if.dout;
    @(negedge clk);
    bus_if.sel = 1'b0;
    bus_if.re  = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    n_cmp = 0;
    n_err = 0;
    rx = 1'b1;
    reset = 1'b1;
    bus_if.sel = 1'b0;
    bus_if.re = 1'b0;
    bus_if.addr = '0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    check("rst_avail", {31'b0, rx_avail}, 32'h0);
    check("rst_overrun", {31'b0, overrun}, 32'h0);
    check("rst_frm_err", {31'b0, frm_err}, 32'h0);
    peek(1'b0, rd); check("rst_data", rd, 32'h0);
    peek(1'b1, rd); check("rst_status", rd, 32'h0);

    // 1: single byte 0x55
    b = 8'h55;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    check("t1_avail_before_stop", {31'b0, rx_avail}, 32'h0);
    drive_bit(1'b1);
    check("t1_avail", {31'b0, rx_avail}, 32'h1);
    cpu_read(1'b0, rd); check("t1_data", rd, 32'h155);
    cpu_read(1'b0, rd); check("t1_data_empty", rd, 32'h0);

    // 2: 17 bytes without reads -> overrun
    for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b1);
    check("t2_overrun", {31'b0, overrun}, 32'h1);
    peek(1'b1, rd); check("t2_status_full", rd, 32'h7);
    for (int i = 0; i < 16; i++) begin
      cpu_read(1'b0, rd);
      check($sformatf("t2_data%0d", i), rd, 32'h100 | i);
    end
    peek(1'b1, rd); check("t2_status_drained", rd, 32'h4);
    cpu_read(1'b1, rd); check("t2_status_read", rd, 32'h4);
    check("t2_overrun_clr", {31'b0, overrun}, 32'h0);

    // 3: short low glitch is rejected
    rx = 1'b0;
    repeat (GLITCH) @(negedge clk);
    rx = 1'b1;
    repeat (3 * BIT_CLKS) @(negedge clk);
    check("t3_avail", {31'b0, rx_avail}, 32'h0);
    check("t3_frm_err", {31'b0, frm_err}, 32'h0);
    peek(1'b1, rd); check("t3_status", rd, 32'h0);

    // 4: framing error, break, then a good frame
    send_frame(8'hA3, 1'b0);
    rx = 1'b0;
    repeat (3 * BIT_CLKS) @(negedge clk);
    check("t4_frm_err", {31'b0, frm_err}, 32'h1);
    check("t4_avail", {31'b0, rx_avail}, 32'h0);
    rx = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    send_frame(8'h3C, 1'b1);
    cpu_read(1'b1, rd); check("t4_status", rd, 32'h9);
    check("t4_frm_clr", {31'b0, frm_err}, 32'h0);
    cpu_read(1'b0, rd); check("t4_data", rd, 32'h13C);

    // 5: held read pops once
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    @(negedge clk);
    bus_if.sel = 1'b1;
    bus_if.re = 1'b1;
    bus_if.addr = '0;
    repeat (10) @(negedge clk);
    bus_if.sel = 1'b0;
    bus_if.re = 1'b0;
    peek(1'b0, rd); check("t5_head", rd, 32'h122);
    cpu_read(1'b0, rd); check("t5_data", rd, 32'h122);
    check("t5_empty", {31'b0, rx_avail}, 32'h0);

    // 6: reset in the middle of a frame
    send_frame(8'h99, 1'b1);
    send_frame(8'h00, 1'b0);
    rx = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    check("t6_pre_status", {28'b0, frm_err, overrun, 1'b0, rx_avail}, 32'h9);
    b = 8'h5A;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    rx = b[4];
    repeat (BIT_CLKS / 2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    reset = 1'b0;
    check("t6_avail", {31'b0, rx_avail}, 32'h0);
    check("t6_overrun", {31'b0, overrun}, 32'h0);
    check("t6_frm_err", {31'b0, frm_err}, 32'h0);
    peek(1'b1, rd); check("t6_status", rd, 32'h0);
    peek(1'b0, rd); check("t6_data", rd, 32'h0);
    repeat (2 * BIT_CLKS) @(negedge clk);
    send_frame(8'h7E, 1'b1);
    cpu_read(1'b0, rd); check("t6_rx_7e", rd, 32'h17E);
    check("t6_final_empty", {31'b0, rx_avail}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
